// File: rtl/axi_sram_pattern_tester.sv
// axi_sram_pattern_tester
//
// AXI-Lite master that exercises an SRAM controller: on start it writes a
// deterministic pattern over [ADDR_FIRST, ADDR_LAST], reads the same range
// back, compares each word and reports pass/fail with an error count and
// the address of the first error. Only one AXI transaction is ever in
// flight, and the write and read phases never overlap.
//
// Optional feature macro: AXI_SRAM_PATTERN_TESTER_LFSR_EN
//   defined     : pattern is a Galois LFSR seeded from seed (0 -> 1), advanced
//                 once per write/read response, reloaded when reads begin.
//   not defined : pattern(addr) = addr[DATA_W-1:0] ^ seed (zero-extended).
//
// Ports
//   axi_clk, axi_reset      clock, synchronous active-high reset
//   start, seed             run request (ignored while busy), pattern seed
//   busy, done, pass        run status; pass valid while done
//   error_count             saturating count of mismatches + bad responses
//   first_err_addr          address of the first error of the run
//   axi_aw*/w*/b*/ar*/r*    AXI-Lite master channels toward the controller
module axi_sram_pattern_tester #(
  parameter int AXI_ADDR_WIDTH = 10,
  parameter int AXI_DATA_WIDTH = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_FIRST = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_LAST  = '1
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      start,
  input  logic [AXI_DATA_WIDTH-1:0] seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               error_count,
  output logic [AXI_ADDR_WIDTH-1:0] first_err_addr,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wstrb,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rvalid,
  output logic                      axi_rready
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   seed_q;

  // Low DW bits of an address, zero-extended when the address is narrower.
  function automatic logic [DW-1:0] addr_bits(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW && i < AW; i++) r[i] = a[i];
    return r;
  endfunction

  logic [AW-1:0] addr_next;
  logic          last_addr;
  logic [DW-1:0] pat_cur;
  logic [DW-1:0] pat_next;
  logic [DW-1:0] pat_first;

  assign addr_next = addr + AW'(1);
  assign last_addr = (addr == ADDR_LAST);

`ifdef AXI_SRAM_PATTERN_TESTER_LFSR_EN
  // Maximal-length Galois taps for the common widths; other widths get a
  // simple non-zero mask so the generator still runs.
  localparam logic [DW-1:0] LFSR_TAPS =
    (DW == 16) ? DW'(16'hB400) :
    (DW == 8)  ? DW'(8'hB8)    :
                 ((DW'(1) << (DW - 1)) | DW'(1));

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  function automatic logic [DW-1:0] seed_nz(input logic [DW-1:0] s);
    return (s == '0) ? DW'(1) : s;
  endfunction

  logic [DW-1:0] lfsr;
  logic [DW-1:0] lfsr_adv;

  assign lfsr_adv  = lfsr_step(lfsr);
  assign pat_cur   = lfsr;
  assign pat_next  = lfsr_adv;
  assign pat_first = seed_nz(seed);

  // The read phase must replay the exact sequence the writes used, so the
  // generator restarts from the seed when the last write response arrives.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      lfsr <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      lfsr <= seed_nz(seed);
    end else if (state == S_WR_RESP && axi_bvalid) begin
      lfsr <= last_addr ? seed_nz(seed_q) : lfsr_adv;
    end else if (state == S_RD_DATA && axi_rvalid) begin
      lfsr <= lfsr_adv;
    end
  end
`else
  assign pat_cur   = addr_bits(addr) ^ seed_q;
  assign pat_next  = addr_bits(addr_next) ^ seed_q;
  assign pat_first = addr_bits(ADDR_FIRST) ^ seed;
`endif

  logic wr_err;
  logic rd_err;
  logic err_hit;
  logic aw_ok;
  logic w_ok;

  assign wr_err  = (state == S_WR_RESP) && axi_bvalid && (axi_bresp != 2'b00);
  assign rd_err  = (state == S_RD_DATA) && axi_rvalid &&
                   ((axi_rresp != 2'b00) || (axi_rdata != pat_cur));
  assign err_hit = wr_err | rd_err;

  // A write channel is finished once its valid is low or handshakes now.
  assign aw_ok = !axi_awvalid || axi_awready;
  assign w_ok  = !axi_wvalid  || axi_wready;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state          <= S_IDLE;
      addr           <= '0;
      seed_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      axi_awaddr     <= '0;
      axi_awvalid    <= 1'b0;
      axi_wdata      <= '0;
      axi_wstrb      <= 1'b0;
      axi_wvalid     <= 1'b0;
      axi_bready     <= 1'b0;
      axi_araddr     <= '0;
      axi_arvalid    <= 1'b0;
      axi_rready     <= 1'b0;
    end else begin
      // At most one error event per cycle; the first one of a run latches
      // its address.
      if (err_hit) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        if (error_count == 16'd0) first_err_addr <= addr;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            seed_q         <= seed;
            addr           <= ADDR_FIRST;
            error_count    <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            axi_awaddr     <= ADDR_FIRST;
            axi_wdata      <= pat_first;
            axi_wstrb      <= 1'b1;
            axi_awvalid    <= 1'b1;
            axi_wvalid     <= 1'b1;
            state          <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            axi_bready <= 1'b1;
            state      <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            if (last_addr) begin
              addr        <= ADDR_FIRST;
              axi_araddr  <= ADDR_FIRST;
              axi_arvalid <= 1'b1;
              state       <= S_RD_REQ;
            end else begin
              addr        <= addr_next;
              axi_awaddr  <= addr_next;
              axi_wdata   <= pat_next;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= S_WR_REQ;
            end
          end
        end

        S_RD_REQ: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            if (last_addr) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              // Include an error reported on this final beat.
              pass  <= (error_count == 16'd0) && !err_hit;
              state <= S_DONE;
            end else begin
              addr        <= addr_next;
              axi_araddr  <= addr_next;
              axi_arvalid <= 1'b1;
              state       <= S_RD_REQ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_pattern_tester.sv
// tb_axi_sram_pattern_tester
//
// Bench for axi_sram_pattern_tester over the range 0x3FC..0x3FF (top of a
// 10-bit space, so the end-of-range compare must stop before the address
// wraps). A small AXI-Lite slave with random ready/response latency stands
// in for the SRAM controller; it can return an error response at a chosen
// address for writes or reads, and can make one cell read back as 8'h00.
// Expected results come from a run-level model of the pattern and error
// rules.
module tb_axi_sram_pattern_tester;

  localparam logic [9:0] FIRST = 10'h3FC;
  localparam logic [9:0] LAST  = 10'h3FF;
  localparam int         NADDR = 4;
  localparam int         MAX_CYCLES = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] seed_in;
  logic       busy, done, pass;
  logic [15:0] error_count;
  logic [9:0] first_err_addr;
  logic [9:0] awaddr, araddr;
  logic       awvalid, awready, wvalid, wready, wstrb;
  logic [7:0] wdata, rdata;
  logic [1:0] bresp, rresp;
  logic       bvalid, bready, arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;

  // Fault injection knobs for the slave.
  logic       bb_en = 1'b0, br_en = 1'b0, cor_en = 1'b0;
  logic [9:0] bb_addr = '0, br_addr = '0, cor_addr = '0;

  always #5 clk = ~clk;

  axi_sram_pattern_tester #(
    .AXI_ADDR_WIDTH(10),
    .AXI_DATA_WIDTH(8),
    .ADDR_FIRST(FIRST),
    .ADDR_LAST(LAST)
  ) dut (
    .axi_clk(clk),
    .axi_reset(rst),
    .start(start),
    .seed(seed_in),
    .busy(busy),
    .done(done),
    .pass(pass),
    .error_count(error_count),
    .first_err_addr(first_err_addr),
    .axi_awaddr(awaddr),
    .axi_awvalid(awvalid),
    .axi_awready(awready),
    .axi_wdata(wdata),
    .axi_wstrb(wstrb),
    .axi_wvalid(wvalid),
    .axi_wready(wready),
    .axi_bresp(bresp),
    .axi_bvalid(bvalid),
    .axi_bready(bready),
    .axi_araddr(araddr),
    .axi_arvalid(arvalid),
    .axi_arready(arready),
    .axi_rdata(rdata),
    .axi_rresp(rresp),
    .axi_rvalid(rvalid),
    .axi_rready(rready)
  );

  // Slave model: one latched write and one latched read at a time, random
  // ready and response delays, reset together with the tester.
  logic [7:0] mem [0:1023];
  logic       have_aw, have_w, have_ar;
  logic [9:0] lat_waddr, lat_raddr;
  logic [7:0] lat_wdata;

  always @(posedge clk) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      bvalid  <= 1'b0; bresp  <= 2'b00;
      rvalid  <= 1'b0; rresp  <= 2'b00; rdata <= 8'h00;
      have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
      lat_waddr <= '0; lat_raddr <= '0; lat_wdata <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else begin
      if (awvalid && awready) begin
        have_aw <= 1'b1; awready <= 1'b0; lat_waddr <= awaddr;
      end else begin
        awready <= !have_aw && ($urandom_range(0, 2) != 0);
      end
      if (wvalid && wready) begin
        have_w <= 1'b1; wready <= 1'b0; lat_wdata <= wdata;
      end else begin
        wready <= !have_w && ($urandom_range(0, 2) != 0);
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end else if (have_aw && have_w && !bvalid && ($urandom_range(0, 1) == 1)) begin
        mem[lat_waddr] <= lat_wdata;
        bvalid  <= 1'b1;
        bresp   <= (bb_en && lat_waddr == bb_addr) ? 2'b10 : 2'b00;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
      end
      if (arvalid && arready) begin
        have_ar <= 1'b1; arready <= 1'b0; lat_raddr <= araddr;
      end else begin
        arready <= !have_ar && !rvalid && ($urandom_range(0, 2) != 0);
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
      end else if (have_ar && !rvalid && ($urandom_range(0, 1) == 1)) begin
        rvalid  <= 1'b1;
        rdata   <= (cor_en && lat_raddr == cor_addr) ? 8'h00 : mem[lat_raddr];
        rresp   <= (br_en && lat_raddr == br_addr) ? 2'b10 : 2'b00;
        have_ar <= 1'b0;
      end
    end
  end

  // Protocol monitor: a valid never drops or changes payload before its
  // handshake, and a new request never overlaps an outstanding transaction.
  int         aw_hs = 0, ar_hs = 0, viol = 0;
  logic       p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [9:0] p_awaddr, p_araddr;
  logic [7:0] p_wdata;
  logic       proto_bad;

  assign proto_bad =
      (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) ||
      (p_wv  && !p_wr  && (!wvalid  || wdata  != p_wdata))  ||
      (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) ||
      (awvalid && (have_aw || bvalid || have_ar || rvalid)) ||
      (wvalid  && (have_w  || bvalid || have_ar || rvalid)) ||
      (arvalid && (have_aw || have_w || bvalid || have_ar || rvalid))
`ifdef AXI_SRAM_PATTERN_TESTER_LFSR_EN
      || (wvalid && wdata == 8'h00)
`endif
      ;

  always @(posedge clk) begin
    if (rst) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0;
      p_arv <= 1'b0; p_arr <= 1'b0;
      p_awaddr <= '0; p_araddr <= '0; p_wdata <= '0;
    end else begin
      if (awvalid && awready) aw_hs <= aw_hs + 1;
      if (arvalid && arready) ar_hs <= ar_hs + 1;
      if (proto_bad) viol <= viol + 1;
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end
  end

  // Pattern expected at offset k of the range for a given seed.
  function automatic logic [7:0] modelPattern(input int k, input logic [7:0] s);
`ifdef AXI_SRAM_PATTERN_TESTER_LFSR_EN
    logic [7:0] v;
    v = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    return v;
`else
    logic [9:0] a;
    a = FIRST + 10'(k);
    return a[7:0] ^ s;
`endif
  endfunction

  // Whole-run outcome: all write-phase errors come first, then read-phase.
  task automatic modelRun(input logic [7:0] s, output int cnt, output logic [9:0] first);
    logic [9:0] a;
    cnt = 0;
    first = '0;
    for (int k = 0; k < NADDR; k++) begin
      a = FIRST + 10'(k);
      if (bb_en && a == bb_addr) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
    for (int k = 0; k < NADDR; k++) begin
      a = FIRST + 10'(k);
      if ((br_en && a == br_addr) ||
          (cor_en && a == cor_addr && modelPattern(k, s) != 8'h00)) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] s);
    @(negedge clk);
    seed_in = s;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < MAX_CYCLES) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [7:0] s);
    int         exp_cnt;
    logic [9:0] exp_first;
    int         mem_bad;
    waitDone();
    modelRun(s, exp_cnt, exp_first);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_count"}, error_count, exp_cnt);
    checkOutput({tag, "_pass"}, pass, (exp_cnt == 0) ? 1 : 0);
    if (exp_cnt != 0) checkOutput({tag, "_first"}, first_err_addr, exp_first);
    mem_bad = 0;
    for (int k = 0; k < NADDR; k++)
      if (mem[FIRST + 10'(k)] !== modelPattern(k, s)) mem_bad++;
    checkOutput({tag, "_mem"}, mem_bad, 0);
  endtask

  typedef struct {
    logic [7:0]  seed;
    logic        bb_en;
    logic [9:0]  bb_addr;
    logic        br_en;
    logic [9:0]  br_addr;
    logic        cor_en;
    logic [9:0]  cor_addr;
    logic        exp_pass;
    logic [15:0] exp_cnt;
    logic [9:0]  exp_first;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int         n;
    int         idle_bad;
    int         aw0, ar0;
    string      tag;

    // Expected values hold for the address-XOR pattern build.
    vecs[0] = '{8'h5A, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 16'd0, 10'h000};
    vecs[1] = '{8'h5A, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h3FE, 1'b0, 16'd1, 10'h3FE};
    vecs[2] = '{8'hFE, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h3FE, 1'b1, 16'd0, 10'h000};
    vecs[3] = '{8'h33, 1'b1, 10'h3FD, 1'b1, 10'h3FD, 1'b0, 10'h000, 1'b0, 16'd2, 10'h3FD};
    vecs[4] = '{8'hC3, 1'b1, 10'h3FF, 1'b0, 10'h000, 1'b1, 10'h3FC, 1'b0, 16'd2, 10'h3FF};
    vecs[5] = '{8'h00, 1'b0, 10'h000, 1'b1, 10'h3FC, 1'b1, 10'h3FC, 1'b0, 16'd1, 10'h3FC};

    rst = 1'b1;
    start = 1'b0;
    seed_in = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_error_count", error_count, 0);
    checkOutput("rst_first_err_addr", first_err_addr, 0);
    checkOutput("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 0);
    rst = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || awvalid || wvalid || bready || arvalid || rready) idle_bad++;
    end
    checkOutput("idle_quiet", idle_bad, 0);

    // Table-driven runs.
    for (int v = 0; v < 6; v++) begin
      bb_en = vecs[v].bb_en; bb_addr = vecs[v].bb_addr;
      br_en = vecs[v].br_en; br_addr = vecs[v].br_addr;
      cor_en = vecs[v].cor_en; cor_addr = vecs[v].cor_addr;
      doReset();
      applyStimulus(vecs[v].seed);
      tag = $sformatf("vec%0d", v);
      checkOutput({tag, "_busy_start"}, busy, 1);
      runAndCheck(tag, vecs[v].seed);
`ifndef AXI_SRAM_PATTERN_TESTER_LFSR_EN
      checkOutput({tag, "_tbl_pass"}, pass, vecs[v].exp_pass);
      checkOutput({tag, "_tbl_count"}, error_count, vecs[v].exp_cnt);
      if (vecs[v].exp_cnt != 16'd0)
        checkOutput({tag, "_tbl_first"}, first_err_addr, vecs[v].exp_first);
`endif
    end

    // Randomized runs against the model.
    for (int r = 0; r < 8; r++) begin
      bb_en  = 1'($urandom_range(0, 1)); bb_addr  = FIRST + 10'($urandom_range(0, 3));
      br_en  = 1'($urandom_range(0, 1)); br_addr  = FIRST + 10'($urandom_range(0, 3));
      cor_en = 1'($urandom_range(0, 1)); cor_addr = FIRST + 10'($urandom_range(0, 3));
      doReset();
      n = int'($urandom_range(0, 255));
      applyStimulus(8'(n));
      runAndCheck($sformatf("rand%0d", r), 8'(n));
    end

    // start while busy is ignored; a later start reruns with a new seed.
    bb_en = 1'b0; br_en = 1'b0; cor_en = 1'b0;
    doReset();
    aw0 = aw_hs;
    ar0 = ar_hs;
    applyStimulus(8'h5A);
    repeat (5) @(negedge clk);
    seed_in = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    runAndCheck("busy_start", 8'h5A);
    checkOutput("busy_start_writes", aw_hs - aw0, NADDR);
    checkOutput("busy_start_reads", ar_hs - ar0, NADDR);
    applyStimulus(8'hC3);
    checkOutput("restart_done_clear", done, 0);
    runAndCheck("restart", 8'hC3);

    // Reset in the middle of the read phase.
    bb_en = 1'b1; bb_addr = 10'h3FD;
    doReset();
    applyStimulus(8'h77);
    n = 0;
    while (!arvalid && n < MAX_CYCLES) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reached_read", arvalid, 1);
    checkOutput("midrst_count_before", error_count, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_arvalid", arvalid, 0);
    checkOutput("midrst_rready", rready, 0);
    checkOutput("midrst_error_count", error_count, 0);
    rst = 1'b0;
    bb_en = 1'b0;
    applyStimulus(8'h3C);
    runAndCheck("after_midrst", 8'h3C);

    checkOutput("protocol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
